datapath_gen: RTL

- Parametrised successor to the SLC-3 datapath. Same control-signal interface, with these changes:
  - data width generalised;
  - fixed-latency memory-wait FSM on the MDR load path;
  - latched PAUSE LED register;
  - bus-contention detection.
- Sits between the ISDU control FSM and the memory/IO bridge.
- Holds PC, MAR, MDR, IR, the register file, NZP and BEN.

---
 rtl/datapath_pkg.sv | 21 ++
 rtl/datapath_gen_reg_file.sv | 30 +++
 rtl/datapath_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared types and helpers for the parametrised SLC-3 datapath.
// Enum encodings match the raw 2-bit control fields driven by the ISDU.
package datapath_pkg;

  localparam int SEXT_W = 64;

  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} alu_op_e;
  typedef enum logic [1:0] {PC_INC, PC_BUS, PC_ADDR, PC_HOLD} pcmux_e;
  typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2mux_e;
  typedef enum logic {IDLE, WAIT} mem_state_e;

  // Sign-extends value[msb:0] to SEXT_W bits; callers size-cast down to DATA_W.
  function automatic logic [SEXT_W-1:0] sext(input logic [15:0] value, input int msb);
    logic signed [SEXT_W-1:0] t;
    t = $signed({value, {(SEXT_W-16){1'b0}}});
    t = t <<< (15 - msb);
    t = t >>> (SEXT_W - 1 - msb);
    return t;
  endfunction

endpackage

// File: rtl/datapath_gen_reg_file.sv
// Eight-entry register file: registered write on LD_REG, combinational reads.
// A write is visible on the read ports only after the edge (no forwarding).
module reg_file_gen #(
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_REG,
  input  logic [2:0]        DR,
  input  logic [2:0]        SR1,
  input  logic [2:0]        SR2,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] SR1_OUT,
  output logic [DATA_W-1:0] SR2_OUT
);

  logic [DATA_W-1:0] r_regs [8];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (LD_REG) begin
      r_regs[DR] <= D;
    end
  end

  assign SR1_OUT = r_regs[SR1];
  assign SR2_OUT = r_regs[SR2];

endmodule

// File: rtl/datapath_gen.sv
// SLC-3 datapath with generic width, sticky bus-contention flag and latched LED.
// Memory reads take MEM_WAIT+1 edges; Mem_Busy asks the controller to hold state.
module datapath_gen
  import datapath_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                MEM_WAIT = 2,
  parameter int                LED_W    = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              LD_IR,
  input  logic              LD_BEN,
  input  logic              LD_CC,
  input  logic              LD_REG,
  input  logic              LD_PC,
  input  logic              LD_LED,
  input  logic              GatePC,
  input  logic              GateMDR,
  input  logic              GateALU,
  input  logic              GateMARMUX,
  input  logic [1:0]        PCMUX,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  input  logic              SR2MUX,
  input  logic              ADDR1MUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic              MIO_EN,
  input  logic [DATA_W-1:0] MDR_In,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic              BEN,
  output logic [LED_W-1:0]  LED,
  output logic              Mem_Busy,
  output logic              Mem_Done,
  output logic              Bus_Err
);

  localparam logic [3:0] WAIT_INIT = 4'((MEM_WAIT == 0) ? 0 : MEM_WAIT - 1);

  logic [DATA_W-1:0] r_pc, r_mar, r_mdr, r_ir;
  logic              r_n, r_z, r_p, r_ben, r_bus_err, r_mem_done;
  logic [LED_W-1:0]  r_led;
  mem_state_e        r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_mem_cap, w_done_nxt, w_multi;
  logic [DATA_W-1:0] w_bus, w_sr1, w_sr2, w_alu, w_alu_b, w_addr1, w_addr2, w_marmux, w_pc_nxt;
  logic [DATA_W-1:0] w_imm5, w_off6, w_off9, w_off11;

  assign w_imm5  = DATA_W'(sext(r_ir[15:0], 4));
  assign w_off6  = DATA_W'(sext(r_ir[15:0], 5));
  assign w_off9  = DATA_W'(sext(r_ir[15:0], 8));
  assign w_off11 = DATA_W'(sext(r_ir[15:0], 10));

  reg_file_gen #(.DATA_W(DATA_W)) u_reg_file (
    .Clk    (Clk),
    .Reset  (Reset),
    .LD_REG (LD_REG),
    .DR     (DRMUX ? 3'd7 : r_ir[11:9]),
    .SR1    (SR1MUX ? r_ir[8:6] : r_ir[11:9]),
    .SR2    (r_ir[2:0]),
    .D      (w_bus),
    .SR1_OUT(w_sr1),
    .SR2_OUT(w_sr2)
  );

  // Contention forces the bus to zero rather than picking a winner.
  assign w_multi = ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1);

  always_comb begin
    w_bus = '0;
    if (!w_multi) begin
      if (GatePC)          w_bus = r_pc;
      else if (GateMDR)    w_bus = r_mdr;
      else if (GateALU)    w_bus = w_alu;
      else if (GateMARMUX) w_bus = w_marmux;
    end
  end

  assign w_alu_b  = SR2MUX ? w_imm5 : w_sr2;
  assign w_addr1  = ADDR1MUX ? w_sr1 : r_pc;
  assign w_marmux = w_addr1 + w_addr2;

  always_comb begin
    w_alu    = w_sr1;
    w_addr2  = '0;
    w_pc_nxt = r_pc;
    case (alu_op_e'(ALUK))
      ALU_ADD:  w_alu = w_sr1 + w_alu_b;
      ALU_AND:  w_alu = w_sr1 & w_alu_b;
      ALU_NOT:  w_alu = ~w_sr1;
      default:  w_alu = w_sr1;
    endcase
    case (addr2mux_e'(ADDR2MUX))
      A2_OFF6:  w_addr2 = w_off6;
      A2_OFF9:  w_addr2 = w_off9;
      A2_OFF11: w_addr2 = w_off11;
      default:  w_addr2 = '0;
    endcase
    case (pcmux_e'(PCMUX))
      PC_INC:  w_pc_nxt = r_pc + DATA_W'(1);
      PC_BUS:  w_pc_nxt = w_bus;
      PC_ADDR: w_pc_nxt = w_marmux;
      default: w_pc_nxt = r_pc;
    endcase
  end

  // Memory-read wait FSM; LD_MDR is ignored entirely while a read is pending.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_cap   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (LD_MDR && MIO_EN) begin
          if (MEM_WAIT == 0) begin
            w_mem_cap  = 1'b1;
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_mem_cap   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc       <= RESET_PC;
      r_mar      <= '0;
      r_mdr      <= '0;
      r_ir       <= '0;
      r_n        <= 1'b0;
      r_z        <= 1'b1;
      r_p        <= 1'b0;
      r_ben      <= 1'b0;
      r_led      <= '0;
      r_bus_err  <= 1'b0;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_mem_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mem_done <= w_done_nxt;
      if (w_multi) r_bus_err <= 1'b1;
      if (LD_MAR)  r_mar <= w_bus;
      if (LD_IR)   r_ir  <= w_bus;
      if (LD_PC)   r_pc  <= w_pc_nxt;
      if (LD_LED)  r_led <= r_ir[LED_W-1:0];
      if (LD_BEN)  r_ben <= |(r_ir[11:9] & {r_n, r_z, r_p});
      if (LD_CC) begin
        r_n <= w_bus[DATA_W-1];
        r_z <= (w_bus == '0);
        r_p <= !w_bus[DATA_W-1] && (w_bus != '0);
      end
      if (w_mem_cap)                                  r_mdr <= MDR_In;
      else if (LD_MDR && !MIO_EN && r_state == IDLE)  r_mdr <= w_bus;
    end
  end

  assign PC       = r_pc;
  assign MAR      = r_mar;
  assign MDR      = r_mdr;
  assign IR       = r_ir;
  assign BEN      = r_ben;
  assign LED      = r_led;
  assign Bus_Err  = r_bus_err;
  assign Mem_Done = r_mem_done;
  assign Mem_Busy = (r_state == WAIT);

endmodule
